// File: rtl/shared_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and protection bit index.
package shared_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int PROT_PRIV  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_slv_state_e;

  // Transfer fields captured on entry to SETUP
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
  } apb_req_t;

  function automatic logic [31:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return {2'b00, addr[ADDR_WIDTH-1:2]};
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Word-addressed register file: byte-enabled synchronous write, asynchronous read, reset clear.
module apb_regfile #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DW/8-1:0]   wstrb,
  input  logic [DW-1:0]     wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DW-1:0]     rdata
);

  localparam int NUM_LANES = DW / 8;

  // One storage array per byte lane keeps each lane's write enable independent
  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    logic [7:0] lane [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) lane[i] <= '0;
      end else if (we && wstrb[b]) begin
        lane[waddr] <= wdata[b*8 +: 8];
      end
    end

    assign rdata[b*8 +: 8] = lane[raddr];
  end

endmodule

// File: rtl/apb_completer.sv
// APB completer with programmable wait states over a small register file.
// Define AMBA4_EN to add PSTRB byte strobes and PPROT privilege checking.
module apb_completer
  import shared_pkg::*;
#(
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
`ifdef AMBA4_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
`endif
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  apb_slv_state_e state, nxt;
  logic [3:0]     cnt;
  apb_req_t       req;
  logic           start, done, load, err, we;
  logic [31:0]    idx;
  logic [DATA_WIDTH/8-1:0] strb;
  logic [DATA_WIDTH-1:0]   rdata;

`ifdef AMBA4_EN
  logic [DATA_WIDTH/8-1:0] lat_strb;
  logic [2:0]              lat_prot;
`endif

  assign start = PSEL & ~PENABLE;
  assign done  = (state == ACCESS) && (cnt == 4'd0);
  // A new setup is accepted from IDLE or on the completing cycle of a transfer
  assign load  = start && ((state == IDLE) || done);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = SETUP;
      SETUP:   nxt = ACCESS;
      ACCESS:  if (done) nxt = start ? SETUP : IDLE;
               else if (!PSEL) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
    end else begin
      state <= nxt;
      if (load) begin
        cnt   <= 4'(WAIT_STATES);
        req   <= '{addr: PADDR, write: PWRITE, wdata: PWDATA};
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt   <= cnt - 4'd1;
      end
    end
  end

`ifdef AMBA4_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      lat_strb <= '0;
      lat_prot <= '0;
    end else if (load) begin
      lat_strb <= PSTRB;
      lat_prot <= PPROT;
    end
  end
  assign strb = lat_strb;
`else
  assign strb = '1;
`endif

  assign idx = word_idx(req.addr);

  always_comb begin
    err = (req.addr[1:0] != 2'b00) || (idx >= 32'(MEM_DEPTH));
`ifdef AMBA4_EN
    if (!lat_prot[PROT_PRIV] && idx >= 32'(MEM_DEPTH / 2)) err = 1'b1;
`endif
  end

  assign we = done & req.write & ~err;

  apb_regfile #(
    .DEPTH (MEM_DEPTH),
    .DW    (DATA_WIDTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (we),
    .waddr (req.addr[2 +: IDX_W]),
    .wstrb (strb),
    .wdata (req.wdata),
    .raddr (req.addr[2 +: IDX_W]),
    .rdata (rdata)
  );

  assign PREADY  = done;
  assign PSLVERR = done & err;
  assign PRDATA  = (done && !req.write && !err) ? rdata : '0;

endmodule

// File: tb/tb_apb_completer.sv
// Randomized self-checking bench for apb_completer against a word-array reference model.
module tb_apb_completer;
  import shared_pkg::*;

  localparam int MEM_DEPTH = 16;
  localparam int WS        = 2;
`ifdef AMBA4_EN
  localparam bit AMBA4 = 1'b1;
`else
  localparam bit AMBA4 = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
`ifdef AMBA4_EN
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
`endif

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] model [MEM_DEPTH];

  always #5 PCLK = ~PCLK;

  apb_completer #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(WS)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
`ifdef AMBA4_EN
    .PSTRB   (PSTRB),
    .PPROT   (PPROT),
`endif
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input logic [2:0] prot);
    logic e;
    e = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(MEM_DEPTH));
    if (AMBA4 && !prot[0] && ((a >> 2) >= 32'(MEM_DEPTH / 2))) e = 1'b1;
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < MEM_DEPTH; i++) model[i] = '0;
  endtask

  task automatic idle();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
  endtask

  // One full transfer starting at a negedge; returns at the completion negedge
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rd, output logic er, output int cyc);
    logic        e;
    logic [31:0] exp_rd;
    e = exp_err(addr, prot);
    exp_rd = '0;
    if (!wr && !e) exp_rd = model[addr >> 2];
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
`ifdef AMBA4_EN
    PSTRB = strb; PPROT = prot;
`endif
    @(negedge PCLK);
    cyc = 1;
    chk({tag, ":setup_ready"}, 32'(PREADY), 32'(0));
    PENABLE = 1'b1;
    // Scramble the bus after setup so only latched values can matter
    PADDR = $urandom; PWDATA = $urandom; PWRITE = $urandom_range(0, 1);
`ifdef AMBA4_EN
    PSTRB = 4'($urandom); PPROT = 3'($urandom);
`endif
    do begin
      @(negedge PCLK);
      cyc++;
    end while (!PREADY && cyc < 40);
    rd = PRDATA;
    er = PSLVERR;
    chk({tag, ":cycles"}, 32'(cyc), 32'(2 + WS));
    chk({tag, ":slverr"}, 32'(er), 32'(e));
    chk({tag, ":prdata"}, rd, exp_rd);
    if (wr && !e)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr >> 2][b*8 +: 8] = wdata[b*8 +: 8];
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        er, wr;
    int          cyc, tot;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
`ifdef AMBA4_EN
    PSTRB = '0; PPROT = '0;
`endif
    model_clear();
    #1;
    chk("reset:pready", 32'(PREADY), 32'(0));
    chk("reset:pslverr", 32'(PSLVERR), 32'(0));
    chk("reset:prdata", PRDATA, 32'(0));
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("idle:pready", 32'(PREADY), 32'(0));

    // Basic write / read back
    xfer("rd08_init", 1'b0, 32'h08, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("rd08_init:val", rd, 32'h0);
    xfer("wr08", 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, cyc);
    idle();
    xfer("rd08", 1'b0, 32'h08, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("rd08:val", rd, 32'hDEADBEEF);
    idle();

    // Error responses
    xfer("rd40", 1'b0, 32'h40, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("rd40:err", 32'(er), 32'(1));
    idle();
    xfer("wr00", 1'b1, 32'h00, 32'hCAFE0001, 4'hF, 3'b001, rd, er, cyc);
    idle();
    xfer("wr03", 1'b1, 32'h03, 32'h99999999, 4'hF, 3'b001, rd, er, cyc);
    chk("wr03:err", 32'(er), 32'(1));
    idle();
    xfer("rd00", 1'b0, 32'h00, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("rd00:unchanged", rd, 32'hCAFE0001);
    idle();

    // Back-to-back writes
    xfer("b2b0", 1'b1, 32'h00, 32'h01010101, 4'hF, 3'b001, rd, er, cyc);
    tot = cyc;
    xfer("b2b1", 1'b1, 32'h04, 32'h02020202, 4'hF, 3'b001, rd, er, cyc);
    tot += cyc;
    chk("b2b:total", 32'(tot), 32'(2 * (2 + WS)));
    idle();
    xfer("b2b_rd0", 1'b0, 32'h00, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("b2b_rd0:val", rd, 32'h01010101);
    xfer("b2b_rd1", 1'b0, 32'h04, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("b2b_rd1:val", rd, 32'h02020202);
    idle();

    // Protocol violation from IDLE is ignored
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("viol:pready", 32'(PREADY), 32'(0));
    end
    idle();
    xfer("viol_rd", 1'b0, 32'h08, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    idle();

    // PSEL drop mid-access aborts with no write
    xfer("wr10", 1'b1, 32'h10, 32'h10101010, 4'hF, 3'b001, rd, er, cyc);
    idle();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'hFFFF0000;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort:pready", 32'(PREADY), 32'(0));
    @(negedge PCLK);
    xfer("abort_rd", 1'b0, 32'h10, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("abort_rd:val", rd, 32'h10101010);
    idle();

    // Reset during the ACCESS wait
    xfer("wr0c", 1'b1, 32'h0C, 32'h55555555, 4'hF, 3'b001, rd, er, cyc);
    idle();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'h12345678;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    chk("rst_mid:pready", 32'(PREADY), 32'(0));
    chk("rst_mid:pslverr", 32'(PSLVERR), 32'(0));
    PSEL = 1'b0; PENABLE = 1'b0;
    model_clear();
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    xfer("rst_rd0c", 1'b0, 32'h0C, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("rst_rd0c:val", rd, 32'h0);

    // Reset on the completion cycle drops PREADY and blocks the write
    xfer("rst_done", 1'b1, 32'h0C, 32'h77777777, 4'hF, 3'b001, rd, er, cyc);
    chk("rst_done:ready_before", 32'(PREADY), 32'(1));
    PRESET = 1'b1;
    #1;
    chk("rst_done:ready_after", 32'(PREADY), 32'(0));
    PSEL = 1'b0; PENABLE = 1'b0;
    model_clear();
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    xfer("rst_done_rd", 1'b0, 32'h0C, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("rst_done_rd:val", rd, 32'h0);
    idle();

`ifdef AMBA4_EN
    xfer("a4_wr", 1'b1, 32'h04, 32'h11223344, 4'hF, 3'b001, rd, er, cyc);
    xfer("a4_strb", 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101, 3'b001, rd, er, cyc);
    idle();
    xfer("a4_rd", 1'b0, 32'h04, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("a4_rd:val", rd, 32'h11BB33DD);
    idle();
    xfer("a4_unpriv", 1'b0, 32'h20, 32'h0, 4'hF, 3'b000, rd, er, cyc);
    chk("a4_unpriv:err", 32'(er), 32'(1));
    idle();
    xfer("a4_priv", 1'b0, 32'h20, 32'h0, 4'hF, 3'b001, rd, er, cyc);
    chk("a4_priv:err", 32'(er), 32'(0));
    idle();
`endif

    // Randomized traffic, mixed idle gaps and back-to-back
    for (int n = 0; n < 150; n++) begin
      logic [3:0] s;
      logic [2:0] p;
      wr = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, MEM_DEPTH - 1)) << 2;
        2:       a = (32'($urandom_range(0, MEM_DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        default: a = 32'($urandom_range(MEM_DEPTH, 63)) << 2;
      endcase
      s = AMBA4 ? 4'($urandom) : 4'hF;
      p = AMBA4 ? 3'($urandom) : 3'b001;
      xfer("rand", wr, a, $urandom, s, p, rd, er, cyc);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb_completer.md
APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16, number of DATA_WIDTH-bit words in the register file.
REQ-002 SHALL have parameter WAIT_STATES, default 2, number of PREADY-low access cycles inserted per transfer (0..15).
REQ-003 SHALL take ADDR_WIDTH (32) and DATA_WIDTH (32) from shared_pkg.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 PCLK  in  1  system clock, rising-edge.
REQ-006 PRESET  in  1  asynchronous active-high reset.
REQ-007 PSEL  in  1  this completer's select bit (one bit of the master's PSELx).
REQ-008 PENABLE  in  1  access-phase indicator.
REQ-009 PWRITE  in  1  1 = write, 0 = read.
REQ-010 PADDR  in  ADDR_WIDTH  byte address.
REQ-011 PWDATA  in  DATA_WIDTH  write data.
REQ-012 PRDATA  out  DATA_WIDTH  read data, valid only while PREADY = 1 on a read.
REQ-013 PREADY  out  1  transfer-complete indication.
REQ-014 PSLVERR  out  1  error response, valid only while PREADY = 1.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-016 IDLE -> SETUP SHALL occur when PSEL = 1 and PENABLE = 0.
REQ-017 Whenever it enters SETUP, the FSM SHALL latch PADDR, PWRITE and PWDATA and load the wait counter with WAIT_STATES.
REQ-018 SETUP -> ACCESS SHALL occur unconditionally on the next edge.
REQ-019 In ACCESS with counter > 0: PREADY = 0, the counter SHALL decrement each cycle, and the state SHALL be held.
REQ-020 PREADY SHALL be combinational and equal to 1 only when state = ACCESS and counter = 0.
REQ-021 On the edge where PREADY = 1, ACCESS SHALL go to SETUP if PSEL = 1 and PENABLE = 0 (back-to-back transfer), and to IDLE otherwise.
REQ-022 A transfer SHALL take 2 + WAIT_STATES cycles from setup to completion.
REQ-023 Error SHALL be flagged when the latched address is misaligned (PADDR[1:0] != 0) or the word index PADDR >> 2 is >= MEM_DEPTH.
REQ-024 On error, PSLVERR = 1 with PREADY = 1, writes SHALL be suppressed, and PRDATA = 0.
REQ-025 A write SHALL commit to the register file only on the edge where PREADY = 1, the latched PWRITE = 1 and there is no error.
REQ-026 PRDATA SHALL be the word at the latched index when PREADY = 1 and the transfer is a read; otherwise PRDATA = 0.
REQ-027 A read completing in the same cycle as a prior write's commit edge SHALL return the new data (registered write, then read in a later access).
REQ-028 PSEL = 1 with PENABLE = 1 while in IDLE (protocol violation) SHALL be ignored: the FSM stays in IDLE and PREADY stays 0.
REQ-029 PSEL dropping to 0 in ACCESS before completion SHALL abort the transfer: return to IDLE, no write.
REQ-030 PREADY and PSLVERR SHALL be 0 in IDLE and SETUP.

Reset
REQ-031 PRESET SHALL asynchronously force state = IDLE, counter = 0 and all register-file words = 0.
REQ-032 During reset, PREADY = 0, PSLVERR = 0 and PRDATA = 0.
REQ-033 PRESET asserted mid-transfer SHALL abort the transfer with no write.

Configuration
REQ-034 Macro AMBA4_EN SHALL add inputs PSTRB (DATA_WIDTH/8) and PPROT (3), both latched in SETUP.
REQ-035 With AMBA4_EN defined, a write SHALL update only the byte lanes whose PSTRB bit is 1.
REQ-036 With AMBA4_EN defined, an access with PPROT[0] = 0 (unprivileged) to word index >= MEM_DEPTH/2 SHALL be an error.
REQ-037 Without AMBA4_EN, the PSTRB and PPROT ports SHALL be absent, writes SHALL be full-word, and there SHALL be no protection check.

Structure
REQ-038 The state enum type apb_slv_state_e and the PROT_PRIV bit index SHALL live in shared_pkg alongside ADDR_WIDTH and DATA_WIDTH.
REQ-039 The register file (write port with byte enables, asynchronous read port, reset clear) SHALL be a sub-module named apb_regfile.

Verification
REQ-040 Reset, then write 0xDEADBEEF to 0x08 with WAIT_STATES = 2 -> PREADY low for 2 cycles then high on cycle 4; PSLVERR = 0; a subsequent read of 0x08 returns 0xDEADBEEF.
REQ-041 Read 0x40 with MEM_DEPTH = 16 -> PREADY = 1 and PSLVERR = 1 with PRDATA = 0; write to 0x03 -> PSLVERR = 1 and memory unchanged.
REQ-042 Back-to-back writes to 0x00 and 0x04 with no IDLE cycle -> both commit; total 2 x (2 + WAIT_STATES) cycles.
REQ-043 Assert PRESET during the ACCESS wait of a write to 0x0C -> PREADY = 0 immediately; a read of 0x0C after reset returns 0.
REQ-044 With AMBA4_EN: write 0xAABBCCDD to 0x04 with PSTRB = 4'b0101 over 0x11223344 -> read returns 0x11BB33DD.
REQ-045 With AMBA4_EN: PPROT = 3'b000 access to 0x20 (MEM_DEPTH = 16) -> PSLVERR = 1; the same access with PPROT = 3'b001 -> PSLVERR = 0.
